ex_muldiv: RTL and testbench

Iterative 32-bit multiply/divide unit in the EX stage, beside the single-cycle ALU. It takes the same signed operand pair the ALU receives. It produces a 64-bit product, or a quotient/remainder pair, into architectural HI/LO registers that the MEM-side result mux reads. While busy it raises a stall to the hazard unit so dependent MFHI/MFLO instructions hold in ID.

---
 rtl/ex_muldiv_pkg.sv | 9 +
 rtl/muldiv_step.sv | 27 ++
 rtl/ex_muldiv.sv | 83 ++++++++
 tb/tb_ex_muldiv.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: op encodings, FSM states and iteration count for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;
    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;
    localparam int ITERS = 32;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 step, shift-add multiply or restoring divide (divide only with EX_MULDIV_DIV_EN).
module muldiv_step #(parameter int WIDTH = 32) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               div,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic               q
);
    logic [WIDTH:0] sum;
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
`ifdef EX_MULDIV_DIV_EN
    logic [WIDTH:0] hx, diff;
    always_comb begin
        hx = acc[2*WIDTH-1:WIDTH-1];
        diff = hx - {1'b0, opnd};
        // The shifted partial remainder fits WIDTH+1 bits, so the top bit of diff is the borrow.
        q = div && !diff[WIDTH];
        acc_nxt = div ? {q ? diff[WIDTH-1:0] : hx[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                      : {sum, acc[WIDTH-1:1]};
    end
`else
    always_comb begin
        q = 1'b0;
        acc_nxt = div ? '0 : {sum, acc[WIDTH-1:1]};
    end
`endif
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32-cycle multiply/divide with HI/LO result registers and a busy stall.
// Divider datapath present only when EX_MULDIV_DIV_EN is defined.
import ex_muldiv_pkg::*;
module ex_muldiv #(parameter int WIDTH = 32) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(ITERS);
    state_t state_q, state_d;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] acc, step_acc, nxt, res;
    logic [WIDTH-1:0] opnd, mag1, mag2;
    logic is_div, neg_q, q, accept, last, sgn;
    assign sgn = op_i == OP_MULT || op_i == OP_DIV;
    assign mag1 = sgn && src1_i[WIDTH-1] ? -src1_i : src1_i;
    assign mag2 = sgn && src2_i[WIDTH-1] ? -src2_i : src2_i;
    assign accept = start_i && !flush_i && state_q != S_RUN;
    assign busy_o = state_q == S_RUN;
    assign done_o = state_q == S_DONE;
    muldiv_step #(.WIDTH(WIDTH)) u_step (.acc(acc), .opnd(opnd), .div(is_div), .acc_nxt(step_acc), .q(q));
    assign nxt = step_acc | {{(2*WIDTH-1){1'b0}}, q};
`ifdef EX_MULDIV_DIV_EN
    logic neg_r;
    logic [WIDTH-1:0] dvd, qm, rm;
    assign qm = nxt[WIDTH-1:0];
    assign rm = nxt[2*WIDTH-1:WIDTH];
    assign last = cnt == CW'(ITERS - 1);
    // Magnitude division makes 0x80000000 / -1 wrap back to 0x80000000 with no special case.
    assign res = !is_div ? (neg_q ? -nxt : nxt)
               : opnd == '0 ? {dvd, {WIDTH{1'b1}}}
               : {neg_r ? -rm : rm, neg_q ? -qm : qm};
`else
    assign last = is_div || cnt == CW'(ITERS - 1);
    assign res = is_div ? '0 : (neg_q ? -nxt : nxt);
`endif
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        state_d = state_q == S_RUN ? (flush_i ? S_IDLE : last ? S_DONE : S_RUN)
                                   : (accept ? S_RUN : S_IDLE);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
            acc <= '0;
            opnd <= '0;
            is_div <= 1'b0;
            neg_q <= 1'b0;
            hi_o <= '0;
            lo_o <= '0;
`ifdef EX_MULDIV_DIV_EN
            neg_r <= 1'b0;
            dvd <= '0;
`endif
        end else if (accept) begin
            cnt <= '0;
            acc <= {{WIDTH{1'b0}}, mag1};
            opnd <= mag2;
            is_div <= op_i == OP_DIV || op_i == OP_DIVU;
            neg_q <= sgn && (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
`ifdef EX_MULDIV_DIV_EN
            neg_r <= sgn && src1_i[WIDTH-1];
            dvd <= src1_i;
`endif
        end else if (state_q == S_RUN && !flush_i) begin
            acc <= nxt;
            cnt <= cnt + 1'b1;
            if (last) {hi_o, lo_o} <= res;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: table-driven vectors plus back-to-back, ignored start, flush and mid-run reset sequences.
import ex_muldiv_pkg::*;
module tb_ex_muldiv;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
    logic [1:0] op = 2'd0;
    logic [31:0] src1 = '0, src2 = '0, hi, lo;
    logic busy, done;
    int n_chk = 0, n_fail = 0;
`ifdef EX_MULDIV_DIV_EN
    localparam bit DE = 1'b1;
`else
    localparam bit DE = 1'b0;
`endif
    typedef struct {
        logic [1:0] op;
        logic [31:0] a, b, hi, lo;
        int lat;
    } vec_t;
    vec_t v[11];
    ex_muldiv #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .src1_i(src1), .src2_i(src2),
        .flush_i(flush), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o;
        src1 = a;
        src2 = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask
    task automatic run_vec(input string nm, input vec_t t);
        int n;
        drive(t.op, t.a, t.b);
        chk({nm, " busy after accept"}, busy, 1);
        wait_done(n);
        chk({nm, " latency"}, n, t.lat);
        chk({nm, " done"}, done, 1);
        chk({nm, " hi"}, hi, t.hi);
        chk({nm, " lo"}, lo, t.lo);
    endtask
    initial begin
        int n;
        v[0]  = '{OP_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 32};
        v[1]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32};
        v[2]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 32};
        v[3]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32};
        v[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        DE ? 32'hFFFFFFFF : 32'h0, DE ? 32'hFFFFFFFD : 32'h0, DE ? 32 : 1};
        v[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,                     DE ? 32'h80000000 : 32'h0, DE ? 32 : 1};
        v[6]  = '{OP_DIVU,  32'd100,      32'd0,        DE ? 32'd100 : 32'h0,      DE ? 32'hFFFFFFFF : 32'h0, DE ? 32 : 1};
        v[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, DE ? 32'd1 : 32'h0,        DE ? 32'hFFFFFFFD : 32'h0, DE ? 32 : 1};
        v[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd2,        DE ? 32'd1 : 32'h0,        DE ? 32'h7FFFFFFF : 32'h0, DE ? 32 : 1};
        v[9]  = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        DE ? 32'hFFFFFFFB : 32'h0, DE ? 32'hFFFFFFFF : 32'h0, DE ? 32 : 1};
        v[10] = '{OP_MULTU, 32'd12345,    32'd1000,     32'h0,                     32'd12345000, 32};
        tick();
        tick();
        rst = 1'b0;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        for (int i = 0; i < 11; i++) begin
            run_vec($sformatf("vec%0d", i), v[i]);
            tick();
            chk($sformatf("vec%0d done single pulse", i), done, 0);
            chk($sformatf("vec%0d idle after done", i), busy, 0);
        end
        run_vec("b2b first", '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32});
        run_vec("b2b second", '{OP_MULT, 32'd2, 32'd3, 32'h0, 32'd6, 32});
        tick();
        drive(OP_MULT, 32'd7, 32'hFFFFFFFD);
        for (int i = 0; i < 4; i++) tick();
        drive(OP_MULTU, 32'd5, 32'd5);
        src1 = 32'hDEADBEEF;
        src2 = 32'h12345678;
        wait_done(n);
        chk("ignored start latency", n, 27);
        chk("ignored start hi", hi, 32'hFFFFFFFF);
        chk("ignored start lo", lo, 32'hFFFFFFEB);
        tick();
        chk("ignored start no requeue", busy, 0);
        drive(OP_MULT, 32'd2, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy", busy, 0);
        chk("flush done", done, 0);
        chk("flush hi kept", hi, 32'hFFFFFFFF);
        chk("flush lo kept", lo, 32'hFFFFFFEB);
        tick();
        chk("flush no later done", done, 0);
        flush = 1'b1;
        drive(OP_MULT, 32'd2, 32'd3);
        flush = 1'b0;
        chk("flush blocks start", busy, 0);
        drive(OP_MULT, 32'd9, 32'd9);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun reset busy", busy, 0);
        chk("midrun reset done", done, 0);
        chk("midrun reset hi", hi, 0);
        chk("midrun reset lo", lo, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
